// File: rtl/i2s_pkg.sv
// Shared types and register offsets for blocks that talk to the I2S_top register port.
package i2s_pkg;

    typedef enum logic [2:0] {
        ST_IDLE = 3'd0,
        ST_RD   = 3'd1,
        ST_CHK  = 3'd2,
        ST_GAP  = 3'd3,
        ST_WR   = 3'd4
    } streamer_state_t;

    localparam logic [31:0] I2S_STATUS_OFS = 32'h0000_0004;
    localparam logic [31:0] I2S_TXDATA_OFS = 32'h0000_0008;

endpackage

// File: rtl/i2s_apb_streamer.sv
// Moves 32-bit stream words into the I2S_top TxFIFO over the register bus,
// polling the status register before every write so the FIFO never overflows.
module i2s_apb_streamer
    import i2s_pkg::*;
#(
    parameter logic [31:0] BASE_ADDR  = 32'h0000_0000,
    parameter logic [31:0] STATUS_OFS = I2S_STATUS_OFS,
    parameter logic [31:0] TXDATA_OFS = I2S_TXDATA_OFS,
    parameter int unsigned TXFULL_BIT = 0,
    parameter int unsigned POLL_GAP   = 8
) (
    input  logic        pclk,
    input  logic        preset,
    input  logic        en,
    input  logic        s_valid,
    input  logic [31:0] s_data,
    output logic        s_ready,
    output logic        penable,
    output logic        pwrite,
    output logic [31:0] paddr,
    output logic [31:0] pwdata,
    input  logic [31:0] prdata,
    output logic        busy,
    output logic [15:0] words_sent
);

    localparam logic [31:0] RD_ADDR  = BASE_ADDR + STATUS_OFS;
    localparam logic [31:0] WR_ADDR  = BASE_ADDR + TXDATA_OFS;
    localparam logic [7:0]  GAP_LOAD = 8'(POLL_GAP - 1);

    streamer_state_t state_q;
    logic        hv_q;
    logic [31:0] hold_q;
    logic        penable_q;
    logic        pwrite_q;
    logic [31:0] paddr_q;
    logic [31:0] pwdata_q;
    logic [7:0]  gap_q;
    logic [15:0] words_sent_q;

    logic        hs_s;
    logic        full_s;
    logic [7:0]  gap_d;
    logic [15:0] words_sent_d;

    assign s_ready      = en & ~hv_q & (state_q == ST_IDLE);
    assign hs_s         = s_valid & s_ready;
    assign full_s       = prdata[TXFULL_BIT];
    assign gap_d        = gap_q - 8'd1;
    assign words_sent_d = words_sent_q + 16'd1;

    // Poll/write sequencer; bus outputs are registered and hold their value while penable is low.
    always_ff @(posedge pclk or negedge preset) begin
        if (!preset) begin
            state_q      <= ST_IDLE;
            hv_q         <= 1'b0;
            hold_q       <= 32'h0000_0000;
            penable_q    <= 1'b0;
            pwrite_q     <= 1'b0;
            paddr_q      <= 32'h0000_0000;
            pwdata_q     <= 32'h0000_0000;
            gap_q        <= 8'd0;
            words_sent_q <= 16'd0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (hs_s) begin
                        hold_q <= s_data;
                        hv_q   <= 1'b1;
                    end
                    if (hs_s || hv_q) begin
                        state_q   <= ST_RD;
                        penable_q <= 1'b1;
                        pwrite_q  <= 1'b0;
                        paddr_q   <= RD_ADDR;
                    end
                end
                ST_RD: begin
                    penable_q <= 1'b0;
                    state_q   <= ST_CHK;
                end
                ST_CHK: begin
                    if (full_s) begin
                        gap_q   <= GAP_LOAD;
                        state_q <= ST_GAP;
                    end else begin
                        state_q   <= ST_WR;
                        penable_q <= 1'b1;
                        pwrite_q  <= 1'b1;
                        paddr_q   <= WR_ADDR;
                        pwdata_q  <= hold_q;
                    end
                end
                ST_GAP: begin
                    if (gap_q == 8'd0) begin
                        state_q   <= ST_RD;
                        penable_q <= 1'b1;
                        pwrite_q  <= 1'b0;
                        paddr_q   <= RD_ADDR;
                    end else begin
                        gap_q <= gap_d;
                    end
                end
                ST_WR: begin
                    penable_q    <= 1'b0;
                    hv_q         <= 1'b0;
                    words_sent_q <= words_sent_d;
                    state_q      <= ST_IDLE;
                end
                default: begin
                    state_q   <= ST_IDLE;
                    penable_q <= 1'b0;
                end
            endcase
        end
    end

    assign penable    = penable_q;
    assign pwrite     = pwrite_q;
    assign paddr      = paddr_q;
    assign pwdata     = pwdata_q;
    assign busy       = hv_q | (state_q != ST_IDLE);
    assign words_sent = words_sent_q;

endmodule

// File: tb/tb_i2s_apb_streamer.sv
// Directed bench for i2s_apb_streamer: a bus monitor logs accesses, the initial block checks them.
module tb_i2s_apb_streamer;

    logic        pclk = 1'b0;
    logic        preset;
    logic        en;
    logic        s_valid, s_valid2;
    logic [31:0] s_data;
    logic        s_ready, s_ready2;
    logic        penable, penable2;
    logic        pwrite, pwrite2;
    logic [31:0] paddr, paddr2;
    logic [31:0] pwdata, pwdata2;
    logic [31:0] prdata, prdata2;
    logic        busy, busy2;
    logic [15:0] words_sent, words_sent2;

    int checks = 0;
    int errors = 0;

    int cyc = 0;
    int rd_cnt = 0;
    int wr_cnt = 0;
    int full_end = 0;
    int          rd_cyc[$];
    int          wr_cyc[$];
    logic [31:0] wr_data[$];
    logic [31:0] wr_addr[$];
    logic [31:0] stream[256];

    always #5 pclk = ~pclk;

    // Status register model: reports full while the read count is below full_end.
    assign prdata  = {31'd0, (rd_cnt < full_end)};
    assign prdata2 = 32'h0000_0000;

    i2s_apb_streamer dut (
        .pclk(pclk), .preset(preset), .en(en), .s_valid(s_valid), .s_data(s_data),
        .s_ready(s_ready), .penable(penable), .pwrite(pwrite), .paddr(paddr),
        .pwdata(pwdata), .prdata(prdata), .busy(busy), .words_sent(words_sent)
    );

    i2s_apb_streamer #(.BASE_ADDR(32'h0000_0020)) dut2 (
        .pclk(pclk), .preset(preset), .en(en), .s_valid(s_valid2), .s_data(s_data),
        .s_ready(s_ready2), .penable(penable2), .pwrite(pwrite2), .paddr(paddr2),
        .pwdata(pwdata2), .prdata(prdata2), .busy(busy2), .words_sent(words_sent2)
    );

    // Bus monitor for the first instance.
    always @(posedge pclk) begin
        cyc = cyc + 1;
        if (penable && !pwrite) begin
            rd_cnt = rd_cnt + 1;
            rd_cyc.push_back(cyc);
        end
        if (penable && pwrite) begin
            wr_cnt = wr_cnt + 1;
            wr_cyc.push_back(cyc);
            wr_data.push_back(pwdata);
            wr_addr.push_back(paddr);
        end
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic wait_idle(input int max_cyc, input string tag);
        int n = 0;
        while (busy && n < max_cyc) begin
            @(negedge pclk);
            n++;
        end
        chk(tag, 32'(busy), 32'd0);
    endtask

    initial begin
        int rs, ws, viol, idx, n, acc;
        logic acc_now;

        preset = 1'b0; en = 1'b0; s_valid = 1'b0; s_valid2 = 1'b0; s_data = 32'h0;
        repeat (2) @(negedge pclk);
        chk("rst_penable", 32'(penable), 32'd0);
        chk("rst_paddr", paddr, 32'd0);
        chk("rst_pwdata", pwdata, 32'd0);
        chk("rst_pwrite", 32'(pwrite), 32'd0);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_words", 32'(words_sent), 32'd0);
        chk("rst_s_ready", 32'(s_ready), 32'd0);
        preset = 1'b1;
        @(negedge pclk);
        chk("rst_s_ready_noen", 32'(s_ready), 32'd0);
        en = 1'b1;
        #1 chk("idle_s_ready", 32'(s_ready), 32'd1);

        // Single word, FIFO not full.
        s_valid = 1'b1; s_data = 32'hDEAD_BEEF;
        @(negedge pclk);
        s_valid = 1'b0;
        chk("t1_rd_penable", 32'(penable), 32'd1);
        chk("t1_rd_pwrite", 32'(pwrite), 32'd0);
        chk("t1_rd_paddr", paddr, 32'h0000_0004);
        chk("t1_rd_s_ready", 32'(s_ready), 32'd0);
        chk("t1_rd_busy", 32'(busy), 32'd1);
        @(negedge pclk);
        s_data = 32'h1234_5678;
        chk("t1_chk_penable", 32'(penable), 32'd0);
        @(negedge pclk);
        chk("t1_wr_penable", 32'(penable), 32'd1);
        chk("t1_wr_pwrite", 32'(pwrite), 32'd1);
        chk("t1_wr_paddr", paddr, 32'h0000_0008);
        chk("t1_wr_pwdata", pwdata, 32'hDEAD_BEEF);
        chk("t1_wr_words", 32'(words_sent), 32'd0);
        @(negedge pclk);
        chk("t1_done_penable", 32'(penable), 32'd0);
        chk("t1_done_words", 32'(words_sent), 32'd1);
        chk("t1_done_s_ready", 32'(s_ready), 32'd1);
        chk("t1_done_busy", 32'(busy), 32'd0);

        // Back-pressure: three full polls, then the write.
        rs = rd_cyc.size(); ws = wr_cyc.size();
        full_end = rd_cnt + 4;
        s_valid = 1'b1; s_data = 32'hCAFE_F00D;
        @(negedge pclk);
        s_valid = 1'b0;
        viol = 0; n = 0;
        while (busy && n < 100) begin
            if (s_ready) viol++;
            @(negedge pclk);
            n++;
        end
        full_end = 0;
        chk("t2_timeout", 32'(busy), 32'd0);
        chk("t2_s_ready_low", 32'(viol), 32'd0);
        chk("t2_reads", 32'(rd_cyc.size() - rs), 32'd4);
        for (int i = 1; i < 4; i++)
            if (rs + i < rd_cyc.size())
                chk($sformatf("t2_spacing%0d", i), 32'(rd_cyc[rs+i] - rd_cyc[rs+i-1]), 32'd10);
        chk("t2_writes", 32'(wr_cyc.size() - ws), 32'd1);
        if (ws < wr_data.size()) chk("t2_wdata", wr_data[ws], 32'hCAFE_F00D);
        chk("t2_words", 32'(words_sent), 32'd2);

        // Streaming 256 words with s_valid held high.
        preset = 1'b0;
        @(negedge pclk);
        preset = 1'b1;
        chk("t3_rst_words", 32'(words_sent), 32'd0);
        for (int i = 0; i < 256; i++) stream[i] = $urandom;
        ws = wr_cyc.size();
        idx = 0; n = 0;
        s_valid = 1'b1; s_data = stream[0];
        while (idx < 256 && n < 1500) begin
            acc_now = s_ready;
            @(negedge pclk);
            n++;
            if (acc_now) begin
                idx++;
                if (idx < 256) s_data = stream[idx];
                else s_valid = 1'b0;
            end
        end
        s_valid = 1'b0;
        chk("t3_accept_all", 32'(idx), 32'd256);
        wait_idle(20, "t3_timeout");
        chk("t3_writes", 32'(wr_cyc.size() - ws), 32'd256);
        viol = 0;
        for (int i = 0; i < 256; i++) begin
            if (ws + i < wr_data.size()) begin
                chk($sformatf("t3_data%0d", i), wr_data[ws+i], stream[i]);
                if (wr_addr[ws+i] !== 32'h0000_0008) viol++;
                if (i > 0 && (wr_cyc[ws+i] - wr_cyc[ws+i-1]) != 4) viol++;
            end
        end
        chk("t3_addr_spacing", 32'(viol), 32'd0);
        chk("t3_words", 32'(words_sent), 32'd256);

        // Enable dropped right after a handshake.
        ws = wr_cyc.size();
        s_valid = 1'b1; s_data = 32'hA5A5_0F0F;
        @(negedge pclk);
        en = 1'b0;
        chk("t4_s_ready", 32'(s_ready), 32'd0);
        wait_idle(20, "t4_timeout");
        chk("t4_writes", 32'(wr_cyc.size() - ws), 32'd1);
        if (ws < wr_data.size()) chk("t4_wdata", wr_data[ws], 32'hA5A5_0F0F);
        chk("t4_words", 32'(words_sent), 32'd257);
        acc = rd_cnt + wr_cnt;
        repeat (20) @(negedge pclk);
        chk("t4_no_access", 32'(rd_cnt + wr_cnt), 32'(acc));
        chk("t4_s_ready_off", 32'(s_ready), 32'd0);
        chk("t4_busy", 32'(busy), 32'd0);
        s_valid = 1'b0;

        // Reset while waiting out a full poll.
        en = 1'b1;
        ws = wr_cyc.size();
        full_end = rd_cnt + 1000;
        s_valid = 1'b1; s_data = 32'h0BAD_CAFE;
        @(negedge pclk);
        s_valid = 1'b0;
        repeat (4) @(negedge pclk);
        chk("t5_in_gap_busy", 32'(busy), 32'd1);
        #2 preset = 1'b0;
        #1;
        chk("t5_penable", 32'(penable), 32'd0);
        chk("t5_words", 32'(words_sent), 32'd0);
        chk("t5_busy", 32'(busy), 32'd0);
        full_end = 0;
        @(negedge pclk);
        preset = 1'b1;
        repeat (20) @(negedge pclk);
        chk("t5_no_write", 32'(wr_cyc.size() - ws), 32'd0);
        chk("t5_idle", 32'(busy), 32'd0);

        // Counter wrap and non-zero base on the second instance.
        force dut2.words_sent_q = 16'hFFFF;
        #1 release dut2.words_sent_q;
        @(negedge pclk);
        chk("t6_preload", 32'(words_sent2), 32'h0000_FFFF);
        s_valid2 = 1'b1;
        s_data = 32'h5EED_1234;
        @(negedge pclk);
        s_valid2 = 1'b0;
        chk("t6_rd_paddr", paddr2, 32'h0000_0024);
        chk("t6_rd_penable", 32'(penable2), 32'd1);
        repeat (2) @(negedge pclk);
        chk("t6_wr_paddr", paddr2, 32'h0000_0028);
        chk("t6_wr_pwrite", 32'(pwrite2), 32'd1);
        chk("t6_wr_pwdata", pwdata2, 32'h5EED_1234);
        @(negedge pclk);
        chk("t6_words_wrap", 32'(words_sent2), 32'd0);
        chk("t6_busy", 32'(busy2), 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
